// File: rtl/hex_display_pkg.sv
// rtl/hex_display_pkg.sv - shared constants, scan state type and hex-to-7-segment lookup
package hex_display_pkg;

   localparam logic [6:0] SEG_OFF = 7'h7F;
   localparam logic [7:0] AN_OFF  = 8'hFF;

   typedef enum logic {
      BLANK = 1'b0,
      DRIVE = 1'b1
   } scan_state_t;

   // Active-low segment pattern {g,f,e,d,c,b,a} for one hex digit
   function automatic logic [6:0] hex7(input logic [3:0] value);
      logic [6:0] seg;
      case (value)
         4'h0:    seg = 7'h40;
         4'h1:    seg = 7'h79;
         4'h2:    seg = 7'h24;
         4'h3:    seg = 7'h30;
         4'h4:    seg = 7'h19;
         4'h5:    seg = 7'h12;
         4'h6:    seg = 7'h02;
         4'h7:    seg = 7'h78;
         4'h8:    seg = 7'h00;
         4'h9:    seg = 7'h10;
         4'hA:    seg = 7'h08;
         4'hB:    seg = 7'h03;
         4'hC:    seg = 7'h46;
         4'hD:    seg = 7'h21;
         4'hE:    seg = 7'h06;
         default: seg = 7'h0E;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - combinational 4-bit to active-low 7-segment decoder
module hex_to_seg7
   import hex_display_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_o
);

   // Pure lookup; the caller registers the result
   always_comb begin
      seg_o = hex7(nibble_i);
   end

endmodule

// File: rtl/hex_display_scanner.sv
// rtl/hex_display_scanner.sv - 8-digit multiplexed 7-segment scanner with frame snapshot and dead time
module hex_display_scanner
   import hex_display_pkg::*;
#(
   parameter int DIV          = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic        clk_i,
   input  logic        nreset_i,
   input  logic [31:0] data_i,
   input  logic        blank_lz_i,
   output logic [7:0]  an_o,
   output logic [6:0]  seg_o,
   output logic        dp_o,
   output logic        frame_o
);

   localparam int              PW          = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0]   PRE_LAST    = PW'(DIV - 1);
   localparam bit              NO_BLANK    = (BLANK_CYCLES == 0);
   localparam logic [PW-1:0]   BLANK_LAST  = PW'(NO_BLANK ? 0 : BLANK_CYCLES - 1);
   // With no dead time the slot starts straight in DRIVE, including out of reset
   localparam scan_state_t     SLOT_START  = NO_BLANK ? DRIVE : BLANK;

   logic [PW-1:0] pre_q, pre_d;
   logic [2:0]    idx_q, idx_d;
   logic [31:0]   shadow_q, shadow_d;
   scan_state_t   state_q, state_d;
   logic          frame_q, frame_d;
   logic [7:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;

   logic          tick;
   logic          frame_end;
   logic [3:0]    cur_nibble;
   logic [6:0]    cur_seg;
   logic [31:0]   upper_bits;
   logic          lz_blank;
   logic          drive_now;

   assign tick       = (pre_q == PRE_LAST);
   assign frame_end  = tick && (idx_q == 3'd7);
   assign cur_nibble = shadow_q[{idx_q, 2'b00} +: 4];

   hex_to_seg7 u_hex_to_seg7 (
      .nibble_i (cur_nibble),
      .seg_o    (cur_seg)
   );

   // Prescaler, digit index, snapshot and slot FSM next-state
   always_comb begin
      pre_d    = tick ? '0 : pre_q + PW'(1);
      idx_d    = tick ? idx_q + 3'd1 : idx_q;
      shadow_d = frame_end ? data_i : shadow_q;
      frame_d  = frame_end;
      state_d  = state_q;
      case (state_q)
         BLANK: begin
            if (tick) begin
               state_d = SLOT_START;
            end else if (pre_q == BLANK_LAST) begin
               state_d = DRIVE;
            end
         end
         DRIVE: begin
            if (tick) begin
               state_d = SLOT_START;
            end
         end
         default: state_d = SLOT_START;
      endcase
   end

   // Output decode: digit is dark in BLANK or when it is a leading zero (digit 0 always lit)
   always_comb begin
      upper_bits = shadow_q >> {idx_q, 2'b00};
      lz_blank   = blank_lz_i && (idx_q != 3'd0) && (upper_bits == 32'd0);
      drive_now  = (state_q == DRIVE) && !lz_blank;
      an_d       = drive_now ? ~(8'b1 << idx_q) : AN_OFF;
      seg_d      = drive_now ? cur_seg : SEG_OFF;
      dp_d       = 1'b1;
   end

   // All state and outputs; anodes and segments update together from one register stage
   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         pre_q    <= '0;
         idx_q    <= 3'd0;
         shadow_q <= 32'd0;
         state_q  <= SLOT_START;
         frame_q  <= 1'b0;
         an_q     <= AN_OFF;
         seg_q    <= SEG_OFF;
         dp_q     <= 1'b1;
      end else begin
         pre_q    <= pre_d;
         idx_q    <= idx_d;
         shadow_q <= shadow_d;
         state_q  <= state_d;
         frame_q  <= frame_d;
         an_q     <= an_d;
         seg_q    <= seg_d;
         dp_q     <= dp_d;
      end
   end

   assign an_o    = an_q;
   assign seg_o   = seg_q;
   assign dp_o    = dp_q;
   assign frame_o = frame_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// tb/tb_hex_display_scanner.sv - directed self-checking bench for hex_display_scanner
module tb_hex_display_scanner;

   localparam logic [6:0] HEX7 [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   logic        clk = 1'b0;
   logic        nreset = 1'b0;
   logic [31:0] data = 32'd0;
   logic        blank_lz = 1'b0;
   logic        blank_lz_b = 1'b0;

   logic [7:0]  an_a, an_b;
   logic [6:0]  seg_a, seg_b;
   logic        dp_a, dp_b;
   logic        frame_a, frame_b;

   int errors = 0;
   int checks = 0;

   logic [7:0] obs_an  [32];
   logic [6:0] obs_seg [32];
   logic       obs_dp  [32];
   logic       obs_fr  [32];

   always #5 clk = ~clk;

   hex_display_scanner #(.DIV(4), .BLANK_CYCLES(1)) dut_a (
      .clk_i      (clk),
      .nreset_i   (nreset),
      .data_i     (data),
      .blank_lz_i (blank_lz),
      .an_o       (an_a),
      .seg_o      (seg_a),
      .dp_o       (dp_a),
      .frame_o    (frame_a)
   );

   hex_display_scanner #(.DIV(4), .BLANK_CYCLES(0)) dut_b (
      .clk_i      (clk),
      .nreset_i   (nreset),
      .data_i     (data),
      .blank_lz_i (blank_lz_b),
      .an_o       (an_b),
      .seg_o      (seg_b),
      .dp_o       (dp_b),
      .frame_o    (frame_b)
   );

   // Sample i is taken after edge i+1 of the frame; each slot is 1 dark + 3 driven samples
   function automatic logic [7:0] exp_an_f(input int i, input logic [7:0] lit);
      int s;
      s = i / 4;
      if ((i % 4) == 0 || !lit[s]) return 8'hFF;
      return ~(8'h01 << s);
   endfunction

   function automatic logic [6:0] exp_seg_f(input int i, input logic [7:0] lit, input logic [31:0] val);
      int s;
      logic [3:0] n;
      s = i / 4;
      if ((i % 4) == 0 || !lit[s]) return 7'h7F;
      n = 4'(val >> (4 * s));
      return HEX7[n];
   endfunction

   task automatic capture_frame(input int change_at, input logic [31:0] new_data);
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         obs_an[i]  = an_a;
         obs_seg[i] = seg_a;
         obs_dp[i]  = dp_a;
         obs_fr[i]  = frame_a;
         if (i == change_at) data = new_data;
      end
   endtask

   task automatic test_reset;
      nreset = 1'b0;
      data   = 32'h76543210;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         checks++;
         if (an_a !== 8'hFF || seg_a !== 7'h7F || dp_a !== 1'b1 || frame_a !== 1'b0 ||
             an_b !== 8'hFF || seg_b !== 7'h7F || frame_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold[%0d] got an=%h seg=%h dp=%b fr=%b b_an=%h b_seg=%h b_fr=%b want an=ff seg=7f dp=1 fr=0",
                     i, an_a, seg_a, dp_a, frame_a, an_b, seg_b, frame_b);
         end
      end
      nreset = 1'b1;
   endtask

   task automatic test_first_frame;
      capture_frame(-1, 32'd0);
      for (int i = 0; i < 32; i++) begin
         checks++;
         if (obs_an[i] !== exp_an_f(i, 8'hFF) || obs_seg[i] !== exp_seg_f(i, 8'hFF, 32'd0) ||
             obs_dp[i] !== 1'b1 || obs_fr[i] !== (i == 31)) begin
            errors++;
            $display("FAIL first_frame[%0d] got an=%h seg=%h dp=%b fr=%b want an=%h seg=%h dp=1 fr=%b",
                     i, obs_an[i], obs_seg[i], obs_dp[i], obs_fr[i],
                     exp_an_f(i, 8'hFF), exp_seg_f(i, 8'hFF, 32'd0), i == 31);
         end
      end
   endtask

   task automatic test_snapshot;
      capture_frame(13, 32'hDEADBEEF);
      for (int i = 0; i < 32; i++) begin
         checks++;
         if (obs_an[i] !== exp_an_f(i, 8'hFF) || obs_seg[i] !== exp_seg_f(i, 8'hFF, 32'h76543210) ||
             obs_fr[i] !== (i == 31)) begin
            errors++;
            $display("FAIL frame_7654[%0d] got an=%h seg=%h fr=%b want an=%h seg=%h fr=%b",
                     i, obs_an[i], obs_seg[i], obs_fr[i],
                     exp_an_f(i, 8'hFF), exp_seg_f(i, 8'hFF, 32'h76543210), i == 31);
         end
      end
      capture_frame(-1, 32'd0);
      for (int i = 0; i < 32; i++) begin
         checks++;
         if (obs_an[i] !== exp_an_f(i, 8'hFF) || obs_seg[i] !== exp_seg_f(i, 8'hFF, 32'hDEADBEEF) ||
             obs_fr[i] !== (i == 31)) begin
            errors++;
            $display("FAIL frame_dead[%0d] got an=%h seg=%h fr=%b want an=%h seg=%h fr=%b",
                     i, obs_an[i], obs_seg[i], obs_fr[i],
                     exp_an_f(i, 8'hFF), exp_seg_f(i, 8'hFF, 32'hDEADBEEF), i == 31);
         end
      end
   endtask

   task automatic test_leading_zero;
      data     = 32'h000000A5;
      blank_lz = 1'b1;
      capture_frame(-1, 32'd0);
      capture_frame(-1, 32'd0);
      for (int i = 0; i < 32; i++) begin
         checks++;
         if (obs_an[i] !== exp_an_f(i, 8'h03) || obs_seg[i] !== exp_seg_f(i, 8'h03, 32'h000000A5) ||
             obs_fr[i] !== (i == 31)) begin
            errors++;
            $display("FAIL lz_a5[%0d] got an=%h seg=%h fr=%b want an=%h seg=%h fr=%b",
                     i, obs_an[i], obs_seg[i], obs_fr[i],
                     exp_an_f(i, 8'h03), exp_seg_f(i, 8'h03, 32'h000000A5), i == 31);
         end
      end
      data = 32'd0;
      capture_frame(-1, 32'd0);
      capture_frame(-1, 32'd0);
      for (int i = 0; i < 32; i++) begin
         checks++;
         if (obs_an[i] !== exp_an_f(i, 8'h01) || obs_seg[i] !== exp_seg_f(i, 8'h01, 32'd0) ||
             obs_fr[i] !== (i == 31)) begin
            errors++;
            $display("FAIL lz_zero[%0d] got an=%h seg=%h fr=%b want an=%h seg=%h fr=%b",
                     i, obs_an[i], obs_seg[i], obs_fr[i],
                     exp_an_f(i, 8'h01), exp_seg_f(i, 8'h01, 32'd0), i == 31);
         end
      end
   endtask

   task automatic test_reset_mid_drive;
      data = 32'h12345678;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (an_a !== 8'hFE || seg_a !== 7'h40) begin
         errors++;
         $display("FAIL pre_reset_drive got an=%h seg=%h want an=fe seg=40", an_a, seg_a);
      end
      nreset = 1'b0;
      #1;
      checks++;
      if (an_a !== 8'hFF || seg_a !== 7'h7F || dp_a !== 1'b1 || frame_a !== 1'b0) begin
         errors++;
         $display("FAIL async_reset got an=%h seg=%h dp=%b fr=%b want an=ff seg=7f dp=1 fr=0",
                  an_a, seg_a, dp_a, frame_a);
      end
      @(negedge clk);
      @(negedge clk);
      nreset = 1'b1;
      capture_frame(-1, 32'd0);
      for (int i = 0; i < 32; i++) begin
         checks++;
         if (obs_an[i] !== exp_an_f(i, 8'h01) || obs_seg[i] !== exp_seg_f(i, 8'h01, 32'd0) ||
             obs_fr[i] !== (i == 31)) begin
            errors++;
            $display("FAIL restart[%0d] got an=%h seg=%h fr=%b want an=%h seg=%h fr=%b",
                     i, obs_an[i], obs_seg[i], obs_fr[i],
                     exp_an_f(i, 8'h01), exp_seg_f(i, 8'h01, 32'd0), i == 31);
         end
      end
   endtask

   task automatic test_no_blank;
      int         pulses;
      int         s;
      logic [7:0] want_an;
      logic [6:0] want_seg;
      logic [3:0] n;
      pulses = 0;
      data   = 32'h89ABCDEF;
      nreset = 1'b0;
      @(negedge clk);
      nreset = 1'b1;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         s        = (i / 4) % 8;
         n        = 4'(data >> (4 * s));
         want_an  = ~(8'h01 << s);
         want_seg = (i < 32) ? 7'h40 : HEX7[n];
         if (frame_b) pulses++;
         checks++;
         if (an_b !== want_an || seg_b !== want_seg || dp_b !== 1'b1 || frame_b !== (i == 31 || i == 63)) begin
            errors++;
            $display("FAIL no_blank[%0d] got an=%h seg=%h dp=%b fr=%b want an=%h seg=%h dp=1 fr=%b",
                     i, an_b, seg_b, dp_b, frame_b, want_an, want_seg, (i == 31 || i == 63));
         end
      end
      checks++;
      if (pulses != 2) begin
         errors++;
         $display("FAIL frame_count got %0d want 2", pulses);
      end
   endtask

   initial begin
      test_reset();
      test_first_frame();
      test_snapshot();
      test_leading_zero();
      test_reset_mid_drive();
      test_no_blank();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
